// File: rtl/mult_accum.sv
// Pipelined unsigned 16x16 multiply-accumulate with grouped results.
// A pair is registered, multiplied, then summed; in_last closes a group and its result is held for a handshake.

module mult16x16_array (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  // Shift-and-add array: one partial-product row per multiplier bit.
  always_comb begin
    p = '0;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) p = p + ({16'b0, a} << i);
    end
  end
endmodule

module mult_accum #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t state, state_next;

  logic        s1_valid, s1_last;
  logic [15:0] s1_a, s1_b;
  logic        s2_valid, s2_last;
  logic [31:0] s2_prod;
  logic [31:0] prod;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             transfer, done, take;
  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_next;

  // No new pair may enter once a closing pair is in flight or a result is held.
  assign in_ready = !rst && (state != HOLD)
                    && !(s1_valid && s1_last) && !(s2_valid && s2_last);
  assign transfer  = in_valid && in_ready;
  assign done      = s2_valid && s2_last;
  assign take      = (state == HOLD) && out_ready;
  assign out_valid = (state == HOLD);

  assign sum      = {1'b0, acc} + (ACC_W+1)'(s2_prod);
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign ovf_next = ovf | sum[ACC_W];

  mult16x16_array u_mult (
    .a (s1_a),
    .b (s1_b),
    .p (prod)
  );

  // NOTE: only the valid bits need reset; the data registers are qualified by them.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= transfer;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (transfer) begin
      s1_a    <= a;
      s1_b    <= b;
      s1_last <= in_last;
    end
    if (s1_valid) begin
      s2_prod <= prod;
      s2_last <= s1_last;
    end
  end

  // NOTE: default the next state first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (transfer) state_next = ACC;
      ACC:     if (done)     state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Running group sum; cleared when the held result is consumed.
  always_ff @(posedge clk) begin
    if (rst || take) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (s2_valid) begin
      acc <= sum[ACC_W-1:0];
      cnt <= cnt_inc;
      ovf <= ovf_next;
    end
  end

  // Result registers capture the final sum including the closing product.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out  <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (state == ACC && done) begin
      acc_out  <= sum[ACC_W-1:0];
      count    <= cnt_inc;
      overflow <= ovf_next;
    end
  end
endmodule

// File: doc/mult_accum.md
MULT_ACCUM -- requirements
Module: mult_accum

Interface
REQ-001 The block SHALL have parameter ACC_W, default 40, giving the accumulator and result width in bits (legal range 32..64).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the product-count output width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand pair is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-007 The block SHALL have ports a and b, inputs, 16 bits each: unsigned multiplicand and multiplier.
REQ-008 The block SHALL have port in_last, input, 1 bit: the presented pair closes the current accumulation group.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is held and valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-011 The block SHALL have port acc_out, output, ACC_W bits: the unsigned sum of all products in the group.
REQ-012 The block SHALL have port count, output, CNT_W bits: the number of products in the group, saturating at all-ones.
REQ-013 The block SHALL have port overflow, output, 1 bit: the group sum exceeded 2^ACC_W-1.

Function
REQ-014 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1.
REQ-015 The block SHALL be a 3-stage pipeline: S1 registers a, b and last; S2 registers the 32-bit product from the team's 16x16 array multiplier block instantiated combinationally between S1 and S2; S3 accumulates.
REQ-016 Each stage SHALL carry a valid bit; a bubble SHALL NOT change the accumulator, count or overflow.
REQ-017 On S2-valid, the accumulator SHALL become acc + zero-extended product, modulo 2^ACC_W.
REQ-018 On the same edge, the count SHALL increment, saturating at 2^CNT_W-1.
REQ-019 The sticky overflow SHALL be set whenever the addition carries out of bit ACC_W-1.
REQ-020 The FSM SHALL have states IDLE (no group open), ACC (group open) and HOLD (result presented).
REQ-021 The FSM SHALL move IDLE->ACC on the first transfer.
REQ-022 The FSM SHALL move ACC->HOLD on the edge where S2-valid and S2-last are both 1; on that edge, acc_out, count and overflow SHALL be loaded with the final values, including that product.
REQ-023 The FSM SHALL move HOLD->IDLE on the edge where out_valid and out_ready are both 1; on that edge, the internal accumulator, count and overflow SHALL be cleared.
REQ-024 out_valid SHALL be 1 exactly in HOLD; acc_out, count and overflow SHALL stay stable while out_valid is 1 and out_ready is 0.
REQ-025 in_ready SHALL be 0 in HOLD and while any S1/S2 entry with last=1 is in flight; otherwise in_ready SHALL be 1.
REQ-026 in_ready SHALL NOT depend combinationally on in_valid.
REQ-027 Latency: a last pair transferred on edge E SHALL produce out_valid=1 in the cycle after edge E+2.
REQ-028 A one-pair group with in_last=1 on its single transfer SHALL be legal and SHALL yield count=1.
REQ-029 A pair 0x0000 x anything SHALL count as a product and add zero.
REQ-030 Back-to-back non-last transfers SHALL be accepted every cycle at full throughput.

Reset
REQ-031 On a rising edge with rst=1, the block SHALL clear all valid bits, the accumulator, count and overflow, and set the FSM to IDLE, overriding any simultaneous transfer or result handshake.
REQ-032 During and after reset: out_valid=0, acc_out=0, count=0, overflow=0.
REQ-033 in_ready SHALL be 0 while rst=1 and SHALL be 1 on the first cycle after rst is released.
REQ-034 Reset mid-group or in HOLD SHALL discard all in-flight pairs and the pending result, with no partial result emitted.

Verification
REQ-035 Bench: single pair a=3, b=5, last=1, out_ready=1 -> out_valid 3 cycles later; acc_out=15, count=1, overflow=0; in_ready low from the transfer until the result is taken.
REQ-036 Bench: 4 back-to-back pairs (0xFFFF,0xFFFF) with last on the 4th -> acc_out=0x3_FFF8_0004, count=4, overflow=0; in_ready high for all 4 cycles.
REQ-037 Bench: ACC_W=32, two pairs (0xFFFF,0xFFFF) -> acc_out=0xFFFC_0002 (wrapped), overflow=1; the next group starts with overflow=0.
REQ-038 Bench: result presented with out_ready held 0 for 5 cycles -> outputs stable, in_ready=0; out_ready=1 -> back to IDLE; a new group accumulates from 0.
REQ-039 Bench: rst=1 asserted one cycle after a last transfer -> no out_valid ever; the next group a=2, b=7 gives acc_out=14, count=1.
REQ-040 Bench: in_valid gapped (1 of 3 cycles), 10 random pairs, last on the 10th -> acc_out and count match a reference model; bubbles alter nothing.
